// File: rtl/psum_drain_if.sv
// rtl/psum_drain_if.sv - capture, element stream and max-report signals of psum_drain
interface psum_drain_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PE     = 4,
  parameter int IDX_WIDTH  = 2
);
  logic                         cap_valid;
  logic                         cap_ready;
  logic [NUM_PE*DATA_WIDTH-1:0] psum_bus;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [IDX_WIDTH-1:0]         out_idx;
  logic                         out_last;
  logic [DATA_WIDTH-1:0]        vec_max;
  logic                         max_valid;

  // master: PE-row producer plus downstream consumer; slave: the drain block
  modport master (
    output cap_valid, psum_bus, out_ready,
    input  cap_ready, out_valid, out_data, out_idx, out_last, vec_max, max_valid
  );

  modport slave (
    input  cap_valid, psum_bus, out_ready,
    output cap_ready, out_valid, out_data, out_idx, out_last, vec_max, max_valid
  );
endinterface

// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - captures a PE-row partial-sum vector, streams it out, reports its signed max
module psum_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PE     = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  psum_drain_if.slave bus
);
  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PE - 1);

  state_t                       r_state;
  state_t                       w_next_state;
  logic [IDX_WIDTH-1:0]         r_idx;
  logic signed [DATA_WIDTH-1:0] r_buf [NUM_PE];
  logic signed [DATA_WIDTH-1:0] r_run_max;
  logic signed [DATA_WIDTH-1:0] r_vec_max;
  logic                         r_max_valid;

  logic                         w_draining;
  logic                         w_last;
  logic                         w_beat;
  logic                         w_last_beat;
  logic                         w_cap_ready;
  logic                         w_cap_fire;
  logic signed [DATA_WIDTH-1:0] w_cur;
  logic signed [DATA_WIDTH-1:0] w_beat_max;

  always_comb begin
    w_draining   = (r_state == S_DRAIN);
    w_cur        = r_buf[r_idx];
    w_last       = w_draining && (r_idx == LAST_IDX);
    w_beat       = w_draining && bus.out_ready;
    w_last_beat  = w_last && bus.out_ready;
    // Reopening capture on the last beat lets vectors run back to back
    w_cap_ready  = !w_draining || w_last_beat;
    w_cap_fire   = bus.cap_valid && w_cap_ready;
    w_beat_max   = (w_cur > r_run_max) ? w_cur : r_run_max;
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_cap_fire) w_next_state = S_DRAIN;
      S_DRAIN: if (w_cap_fire) w_next_state = S_DRAIN;
               else if (w_last_beat) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx       <= '0;
      r_run_max   <= '0;
      r_vec_max   <= '0;
      r_max_valid <= 1'b0;
      for (int k = 0; k < NUM_PE; k++) r_buf[k] <= '0;
    end else begin
      r_max_valid <= w_last_beat;
      if (w_last_beat) r_vec_max <= w_beat_max;
      // A capture on the finishing beat wins over the beat's own idx/max update
      if (w_cap_fire) begin
        for (int k = 0; k < NUM_PE; k++) r_buf[k] <= bus.psum_bus[k*DATA_WIDTH +: DATA_WIDTH];
        r_idx     <= '0;
        r_run_max <= bus.psum_bus[DATA_WIDTH-1:0];
      end else if (w_beat) begin
        r_run_max <= w_beat_max;
        r_idx     <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

  assign bus.cap_ready = w_cap_ready;
  assign bus.out_valid = w_draining;
  assign bus.out_data  = w_draining ? w_cur : '0;
  assign bus.out_idx   = r_idx;
  assign bus.out_last  = w_last;
  assign bus.vec_max   = r_vec_max;
  assign bus.max_valid = r_max_valid;
endmodule

// File: tb/tb_psum_drain.sv
// tb/tb_psum_drain.sv - directed self-checking bench for psum_drain
module tb_psum_drain;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;
  int   cyc = 0;

  int q_data[$];
  int q_idx[$];
  int q_last[$];
  int q_cyc[$];
  int q_max[$];

  psum_drain_if #(.DATA_WIDTH(16), .NUM_PE(4), .IDX_WIDTH(2)) bus ();

  psum_drain #(.DATA_WIDTH(16), .NUM_PE(4), .IDX_WIDTH(2)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor samples at negedge: inputs change just after posedge, so this is what the next edge sees
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        q_data.push_back(int'($signed(bus.out_data)));
        q_idx.push_back(int'(bus.out_idx));
        q_last.push_back(int'(bus.out_last));
        q_cyc.push_back(cyc);
      end
      if (bus.max_valid) q_max.push_back(int'($signed(bus.vec_max)));
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic clear_q();
    q_data.delete(); q_idx.delete(); q_last.delete(); q_cyc.delete(); q_max.delete();
  endtask

  task automatic wait_cap_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.cap_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({tag, "_cap_timeout"}, 0, 1);
  endtask

  task automatic do_capture(input string tag, input logic [63:0] v);
    bus.cap_valid = 1'b1;
    bus.psum_bus  = v;
    wait_cap_ready(tag);
    @(posedge clk);
    #1 bus.cap_valid = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_beats"}, q_data.size(), 4);
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), q_data[i], e[i]);
      chk($sformatf("%s_idx%0d", tag, i), q_idx[i], i);
      chk($sformatf("%s_last%0d", tag, i), q_last[i], (i == 3) ? 1 : 0);
    end
  endtask

  task automatic check_max(input string tag, input int exp);
    chk({tag, "_max_cnt"}, q_max.size(), 1);
    if (q_max.size() > 0) chk({tag, "_vec_max"}, q_max[0], exp);
  endtask

  initial begin
    bus.cap_valid = 1'b0;
    bus.psum_bus  = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_cap_ready", int'(bus.cap_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_idx", int'(bus.out_idx), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_vec_max", int'(bus.vec_max), 0);
    chk("rst_max_valid", int'(bus.max_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single vector, first element visible the cycle after capture
    bus.out_ready = 1'b1;
    clear_q();
    do_capture("single", pack4(10, -3, 7, 2));
    @(negedge clk);
    chk("t1_first_valid", int'(bus.out_valid), 1);
    chk("t1_first_idx", int'(bus.out_idx), 0);
    chk("t1_first_data", int'($signed(bus.out_data)), 10);
    repeat (8) @(negedge clk);
    check_stream("single", 10, -3, 7, 2);
    check_max("single", 10);
    chk("single_idle_cap_ready", int'(bus.cap_ready), 1);
    chk("single_idle_out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;

    // backpressure on element 1
    clear_q();
    do_capture("bp", pack4(10, -3, 7, 2));
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_data%0d", i), int'($signed(bus.out_data)), -3);
      chk($sformatf("bp_hold_idx%0d", i), int'(bus.out_idx), 1);
      chk($sformatf("bp_hold_valid%0d", i), int'(bus.out_valid), 1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check_stream("bp", 10, -3, 7, 2);
    check_max("bp", 10);
    @(posedge clk); #1;

    // back to back with cap_valid held
    clear_q();
    bus.cap_valid = 1'b1;
    bus.psum_bus  = pack4(1, 2, 3, 4);
    wait_cap_ready("b2b_a");
    @(posedge clk);
    #1 bus.psum_bus = pack4(-8, -1, -5, -2);
    wait_cap_ready("b2b_b");
    @(posedge clk);
    #1 bus.cap_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("b2b_beats", q_data.size(), 8);
    if (q_data.size() == 8) begin
      int e[8];
      e = '{1, 2, 3, 4, -8, -1, -5, -2};
      for (int i = 0; i < 8; i++) chk($sformatf("b2b_data%0d", i), q_data[i], e[i]);
      chk("b2b_no_bubble", q_cyc[7] - q_cyc[0], 7);
    end
    chk("b2b_max_cnt", q_max.size(), 2);
    if (q_max.size() == 2) begin
      chk("b2b_max0", q_max[0], 4);
      chk("b2b_max1", q_max[1], -1);
    end
    @(posedge clk); #1;

    // signed extremes
    clear_q();
    do_capture("ext1", pack4(-32768, -32768, 32767, -1));
    repeat (8) @(negedge clk);
    check_stream("ext1", -32768, -32768, 32767, -1);
    check_max("ext1", 32767);
    @(posedge clk); #1;
    clear_q();
    do_capture("ext2", pack4(-32768, -32768, -32768, -32768));
    repeat (8) @(negedge clk);
    check_max("ext2", -32768);
    @(posedge clk); #1;

    // capture offered mid-drain must be ignored
    clear_q();
    do_capture("busy", pack4(5, 5, 5, 5));
    @(posedge clk);
    #1 begin
      bus.cap_valid = 1'b1;
      bus.psum_bus  = pack4(9, 9, 9, 9);
    end
    @(negedge clk);
    chk("busy_cap_ready", int'(bus.cap_ready), 0);
    @(posedge clk);
    #1 bus.cap_valid = 1'b0;
    repeat (8) @(negedge clk);
    check_stream("busy", 5, 5, 5, 5);
    check_max("busy", 5);
    @(posedge clk); #1;

    // reset after element 1 transfers
    clear_q();
    do_capture("rstm", pack4(3, 8, 1, 6));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstm_out_valid", int'(bus.out_valid), 0);
    chk("rstm_out_idx", int'(bus.out_idx), 0);
    chk("rstm_cap_ready", int'(bus.cap_ready), 1);
    chk("rstm_vec_max", int'(bus.vec_max), 0);
    chk("rstm_beats_before", q_data.size(), 2);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstm_no_max", q_max.size(), 0);
    @(posedge clk); #1;
    clear_q();
    do_capture("after", pack4(4, -2, 9, 0));
    repeat (8) @(negedge clk);
    check_stream("after", 4, -2, 9, 0);
    check_max("after", 9);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
